// File: rtl/sprite_enable_sched_pkg.sv
// rtl/sprite_enable_sched_pkg.sv - shared sprite enable widths and scheduler state encodings
package sprite_enable_sched_pkg;
    localparam int NUM_SPRITES = 4;
    localparam int SPR_EN_BITS = 3;
    localparam int EN_W        = NUM_SPRITES * SPR_EN_BITS;
    localparam int ADDR_W      = 3;
    localparam int DEPTH       = 2 ** ADDR_W;
    localparam int FPS_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/sprite_enable_sched_tick.sv
// rtl/sprite_enable_sched_tick.sv - frame_tick_gen: one-cycle tick on vsync becoming active
module frame_tick_gen #(
    parameter logic VSYNC_ACT = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic vsync,
    output logic tick
);
    logic vsync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) vsync_q <= ~VSYNC_ACT;
        else         vsync_q <= vsync;
    end

    assign tick = (vsync == VSYNC_ACT) && (vsync_q != VSYNC_ACT);
endmodule

// File: rtl/sprite_enable_sched.sv
// rtl/sprite_enable_sched.sv - frame-synchronous sequencer of sprite enable patterns
module sprite_enable_sched
    import sprite_enable_sched_pkg::*;
#(
    parameter logic VSYNC_ACT = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              vsync,
    input  logic              run,
    input  logic              loop,
    input  logic              restart,
    input  logic [FPS_W-1:0]  frames_per_step,
    input  logic [ADDR_W-1:0] seq_len,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [EN_W-1:0]   wr_data,
    output logic [EN_W-1:0]   enables,
    output logic [ADDR_W-1:0] step_idx,
    output logic              step_pulse,
    output logic              done
);
    logic              tick;
    state_t            state, state_n;
    logic [FPS_W-1:0]  fcnt, fcnt_n, fps_eff;
    logic              restart_pend, clr_pend;
    logic              load;
    logic [ADDR_W-1:0] load_idx;
    logic [EN_W-1:0]   tbl [DEPTH];

    frame_tick_gen #(.VSYNC_ACT(VSYNC_ACT)) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .vsync  (vsync),
        .tick   (tick)
    );

    assign fps_eff = (frames_per_step == '0) ? FPS_W'(1) : frames_per_step;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    // Pattern loads are decided here; the registered datapath below applies them.
    always_comb begin
        state_n  = state;
        fcnt_n   = fcnt;
        load     = 1'b0;
        load_idx = step_idx;
        clr_pend = 1'b0;
        case (state)
            IDLE: if (tick && run) begin
                load     = 1'b1;
                load_idx = '0;
                fcnt_n   = '0;
                state_n  = RUN;
            end
            RUN: if (tick && run) begin
                if (restart_pend) begin
                    load     = 1'b1;
                    load_idx = '0;
                    fcnt_n   = '0;
                    clr_pend = 1'b1;
                end else if (fcnt == fps_eff - FPS_W'(1)) begin
                    fcnt_n = '0;
                    if (step_idx < seq_len) begin
                        load     = 1'b1;
                        load_idx = step_idx + ADDR_W'(1);
                    end else if (loop) begin
                        load     = 1'b1;
                        load_idx = '0;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    fcnt_n = fcnt + FPS_W'(1);
                end
            end
            DONE: if (tick && run && restart_pend) begin
                load     = 1'b1;
                load_idx = '0;
                fcnt_n   = '0;
                clr_pend = 1'b1;
                state_n  = RUN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        done = (state == DONE);
    end

    // Table read below sees the pre-write value when wr_en hits the same entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enables      <= '0;
            step_idx     <= '0;
            step_pulse   <= 1'b0;
            fcnt         <= '0;
            restart_pend <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else begin
            fcnt         <= fcnt_n;
            step_pulse   <= load;
            restart_pend <= (state_n == IDLE) ? 1'b0
                          : ((restart_pend && !clr_pend) || (restart && state != IDLE));
            if (load) begin
                enables  <= tbl[load_idx];
                step_idx <= load_idx;
            end
            if (wr_en) tbl[wr_addr] <= wr_data;
        end
    end
endmodule
